// File: rtl/counter_event_monitor.sv
// Watches a 4-bit up/down count stream, classifies each sampled transition and
// queues one event per classified sample in a small first-word-fall-through FIFO.
module counter_event_monitor #(
    parameter logic [3:0] THRESH = 4'd8,
    parameter int         DEPTH  = 4,
    parameter int         WCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        count,
    input  logic              clr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_code,
    output logic [3:0]        evt_count,
    output logic [WCNT_W-1:0] wrap_cnt,
    output logic              overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]     PTR_ONE  = 1;
    localparam logic [AW:0]       OCC_ONE  = 1;
    localparam logic [AW:0]       OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [WCNT_W-1:0] WCNT_ONE = 1;

    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_WRAP_UP = 3'd1,
        EV_WRAP_DN = 3'd2,
        EV_REV_UP  = 3'd3,
        EV_REV_DN  = 3'd4,
        EV_THR_UP  = 3'd5,
        EV_THR_DN  = 3'd6,
        EV_JUMP    = 3'd7
    } evt_e;

    logic [3:0] prev;
    logic       prev_vld;
    logic       last_up;
    logic       dir_vld;

    logic       sample;
    logic [3:0] delta;
    logic       step_up;
    logic       step_dn;
    logic       jump;
    evt_e       code;

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          drop;

    // Transition classification against the previous sample (mod-16 delta).
    assign sample  = in_valid & prev_vld;
    assign delta   = count - prev;
    assign step_up = sample & (delta == 4'd1);
    assign step_dn = sample & (delta == 4'hF);
    assign jump    = sample & (delta != 4'd0) & ~step_up & ~step_dn;

    always_comb begin
        code = EV_NONE;
        if (jump)
            code = EV_JUMP;
        else if (step_up && prev == 4'hF)
            code = EV_WRAP_UP;
        else if (step_dn && prev == 4'h0)
            code = EV_WRAP_DN;
        else if (step_up && dir_vld && !last_up)
            code = EV_REV_UP;
        else if (step_dn && dir_vld && last_up)
            code = EV_REV_DN;
        else if (step_up && count == THRESH)
            code = EV_THR_UP;
        else if (step_dn && prev == THRESH)
            code = EV_THR_DN;
    end

    // Sample history is kept across clr; only reset forgets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= 4'd0;
            prev_vld <= 1'b0;
            last_up  <= 1'b0;
            dir_vld  <= 1'b0;
        end else if (in_valid) begin
            prev     <= count;
            prev_vld <= 1'b1;
            if (jump) begin
                dir_vld <= 1'b0;
            end else if (step_up || step_dn) begin
                dir_vld <= 1'b1;
                last_up <= step_up;
            end
        end
    end

    // Output handshake: the head event transfers on a cycle where evt_valid and
    // evt_ready are both high; evt_valid never drops without a transfer except on clr.
    assign push    = (code != EV_NONE);
    assign full    = (occ == OCC_FULL);
    assign pop     = evt_valid & evt_ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok && !clr)
            mem[wr_ptr] <= {code, count};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overflow <= 1'b0;
        else if (clr)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

    // Wraps are counted even when the FIFO has no room for the event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wrap_cnt <= '0;
        else if (clr)
            wrap_cnt <= '0;
        else if ((code == EV_WRAP_UP || code == EV_WRAP_DN) && wrap_cnt != '1)
            wrap_cnt <= wrap_cnt + WCNT_ONE;
    end

    assign evt_valid = (occ != '0);
    assign evt_code  = evt_valid ? mem[rd_ptr][6:4] : 3'd0;
    assign evt_count = evt_valid ? mem[rd_ptr][3:0] : 4'd0;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Bench for counter_event_monitor: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of the event stream.
module tb_counter_event_monitor;

    localparam logic [3:0] THRESH = 4'd8;
    localparam int         DEPTH  = 4;
    localparam int         WCNT_W = 8;
    localparam int         WMAX   = (1 << WCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [3:0]        count = 4'd0;
    logic              clr = 1'b0;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [2:0]        evt_code;
    logic [3:0]        evt_count;
    logic [WCNT_W-1:0] wrap_cnt;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    // Reference model state: pending events, wrap total, drop flag, sample history.
    logic [6:0] exp_q[$];
    int         exp_wrap;
    bit         exp_ovf;
    int         m_prev;
    bit         m_prev_vld;
    bit         m_dir_vld;
    bit         m_last_up;

    counter_event_monitor #(
        .THRESH(THRESH),
        .DEPTH (DEPTH),
        .WCNT_W(WCNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .count    (count),
        .clr      (clr),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_count(evt_count),
        .wrap_cnt (wrap_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        exp_q.delete();
        exp_wrap   = 0;
        exp_ovf    = 1'b0;
        m_prev     = 0;
        m_prev_vld = 1'b0;
        m_dir_vld  = 1'b0;
        m_last_up  = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model for that edge, return #1 after the edge.
    task automatic drive(input bit v, input int c, input bit r, input bit cl);
        int  code;
        int  d;
        bit  up;
        bit  do_pop;
        in_valid  = v;
        count     = c[3:0];
        evt_ready = r;
        clr       = cl;
        code      = 0;
        do_pop    = (exp_q.size() != 0) && r;
        if (v) begin
            if (!m_prev_vld) begin
                m_prev_vld = 1'b1;
            end else begin
                d = (c - m_prev + 16) % 16;
                if (d == 1 || d == 15) begin
                    up = (d == 1);
                    if (up && m_prev == 15)                    code = 1;
                    else if (!up && m_prev == 0)               code = 2;
                    else if (m_dir_vld && up && !m_last_up)    code = 3;
                    else if (m_dir_vld && !up && m_last_up)    code = 4;
                    else if (up && c == int'(THRESH))          code = 5;
                    else if (!up && m_prev == int'(THRESH))    code = 6;
                    m_last_up = up;
                    m_dir_vld = 1'b1;
                end else if (d != 0) begin
                    code      = 7;
                    m_dir_vld = 1'b0;
                end
            end
            m_prev = c;
        end
        if ((code == 1 || code == 2) && exp_wrap < WMAX)
            exp_wrap++;
        if (cl) begin
            exp_q.delete();
            exp_ovf  = 1'b0;
            exp_wrap = 0;
        end else begin
            if (do_pop)
                void'(exp_q.pop_front());
            if (code != 0) begin
                if (exp_q.size() < DEPTH)
                    exp_q.push_back({3'(code), 4'(c)});
                else
                    exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({evt_valid, evt_code, evt_count, wrap_cnt, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b code=%0d cnt=%0d wrap=%0d ovf=%0b, expected all zero",
                     evt_valid, evt_code, evt_count, wrap_cnt, overflow);
        end
        rst = 1'b1;
    endtask

    task automatic test_ramp();
        bit exp_v;
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, i % 16, 1'b1, 1'b0);
            exp_v = (i == 8) || (i == 16);
            checks++;
            if (evt_valid !== exp_v) begin
                errors++;
                $display("FAIL ramp_valid[%0d]: got %0b expected %0b", i, evt_valid, exp_v);
            end
            if (i == 8) begin
                checks++;
                if ({evt_code, evt_count} !== {3'd5, 4'd8}) begin
                    errors++;
                    $display("FAIL ramp_thr_up: got code=%0d cnt=%0d expected code=5 cnt=8", evt_code, evt_count);
                end
            end
            if (i == 16) begin
                checks++;
                if ({evt_code, evt_count} !== {3'd1, 4'd0}) begin
                    errors++;
                    $display("FAIL ramp_wrap_up: got code=%0d cnt=%0d expected code=1 cnt=0", evt_code, evt_count);
                end
            end
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (wrap_cnt !== 8'd1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_wrap_cnt: got wrap=%0d v=%0b expected wrap=1 v=0", wrap_cnt, evt_valid);
        end
    endtask

    task automatic test_reversal();
        int         seq [6] = '{5, 6, 7, 6, 6, 7};
        logic [6:0] exp_ev [3] = '{{3'd7, 4'd5}, {3'd4, 4'd6}, {3'd3, 4'd7}};
        logic [6:0] got[$];
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i], 1'b1, 1'b0);
            if (evt_valid) got.push_back({evt_code, evt_count});
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL rev_event_count: got %0d expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_ev[i]) begin
                    errors++;
                    $display("FAIL rev_event[%0d]: got code=%0d cnt=%0d expected code=%0d cnt=%0d",
                             i, got[i][6:4], got[i][3:0], exp_ev[i][6:4], exp_ev[i][3:0]);
                end
            end
        end
    endtask

    task automatic test_wrap_dn();
        int         seq [4] = '{14, 15, 0, 15};
        logic [6:0] exp_ev [3] = '{{3'd7, 4'd14}, {3'd1, 4'd0}, {3'd2, 4'd15}};
        logic [6:0] got[$];
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i], 1'b1, 1'b0);
            if (evt_valid) got.push_back({evt_code, evt_count});
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL wrapdn_event_count: got %0d expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_ev[i]) begin
                    errors++;
                    $display("FAIL wrapdn_event[%0d]: got code=%0d cnt=%0d expected code=%0d cnt=%0d",
                             i, got[i][6:4], got[i][3:0], exp_ev[i][6:4], exp_ev[i][3:0]);
                end
            end
        end
        checks++;
        if (wrap_cnt !== 8'd3) begin
            errors++;
            $display("FAIL wrapdn_wrap_cnt: got %0d expected 3", wrap_cnt);
        end
    endtask

    task automatic test_jump();
        int         seq [3] = '{3, 9, 10};
        logic [6:0] exp_ev [2] = '{{3'd7, 4'd3}, {3'd7, 4'd9}};
        logic [6:0] got[$];
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, seq[i], 1'b1, 1'b0);
            if (evt_valid) got.push_back({evt_code, evt_count});
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL jump_event_count: got %0d expected 2", got.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got[i] !== exp_ev[i]) begin
                    errors++;
                    $display("FAIL jump_event[%0d]: got code=%0d cnt=%0d expected code=%0d cnt=%0d",
                             i, got[i][6:4], got[i][3:0], exp_ev[i][6:4], exp_ev[i][3:0]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int seq [6] = '{2, 7, 12, 1, 6, 11};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i], 1'b0, 1'b0);
            if (i == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_exactly_full: got overflow=%0b expected 0", overflow);
                end
            end
        end
        checks++;
        if (evt_valid !== 1'b1 || {evt_code, evt_count} !== {3'd7, 4'd2} || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full_head: got v=%0b code=%0d cnt=%0d ovf=%0b expected v=1 code=7 cnt=2 ovf=1",
                     evt_valid, evt_code, evt_count, overflow);
        end
        drive(1'b1, 0, 1'b1, 1'b0);
        checks++;
        if ({evt_code, evt_count} !== {3'd7, 4'd7} || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pop_push_head: got code=%0d cnt=%0d ovf=%0b expected code=7 cnt=7 ovf=1",
                     evt_code, evt_count, overflow);
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || {evt_code, evt_count} !== {3'd7, 4'd1}) begin
            errors++;
            $display("FAIL ovf_drain_order: got v=%0b code=%0d cnt=%0d expected v=1 code=7 cnt=1",
                     evt_valid, evt_code, evt_count);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || {evt_code, evt_count} !== {3'd7, 4'd1}) begin
            errors++;
            $display("FAIL ovf_pop_pushed_entry: got v=%0b code=%0d cnt=%0d expected v=1 code=7 cnt=1",
                     evt_valid, evt_code, evt_count);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b0 || wrap_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ovf_clr: got v=%0b ovf=%0b wrap=%0d expected 0 0 0", evt_valid, overflow, wrap_cnt);
        end
    endtask

    task automatic test_wrap_sat();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, (i % 2 == 0) ? 15 : 0, 1'b1, 1'b0);
            if (i == 253) begin
                checks++;
                if (wrap_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_before_top: got %0d expected 254", wrap_cnt);
                end
            end
        end
        checks++;
        if (wrap_cnt !== 8'd255 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_wrap_cnt: got wrap=%0d ovf=%0b expected wrap=255 ovf=0", wrap_cnt, overflow);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({evt_valid, evt_code, evt_count, wrap_cnt, overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b code=%0d cnt=%0d wrap=%0d ovf=%0b expected all zero",
                     evt_valid, evt_code, evt_count, wrap_cnt, overflow);
        end
        m_reset();
        #2;
        rst = 1'b1;
        drive(1'b1, 15, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first_sample: got v=%0b expected 0", evt_valid);
        end
        drive(1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || {evt_code, evt_count} !== {3'd1, 4'd0} || wrap_cnt !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_wrap: got v=%0b code=%0d cnt=%0d wrap=%0d expected v=1 code=1 cnt=0 wrap=1",
                     evt_valid, evt_code, evt_count, wrap_cnt);
        end
    endtask

    task automatic test_random();
        int cur;
        int sel;
        int nxt;
        cur = 0;
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)      nxt = (cur + 1) % 16;
            else if (sel <= 6) nxt = (cur + 15) % 16;
            else if (sel == 7) nxt = cur;
            else               nxt = $urandom_range(0, 15);
            drive($urandom_range(0, 3) != 0, nxt, $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
            cur = nxt;
            checks++;
            if (evt_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %0b expected %0b", n, evt_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({evt_code, evt_count} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got code=%0d cnt=%0d expected code=%0d cnt=%0d",
                             n, evt_code, evt_count, exp_q[0][6:4], exp_q[0][3:0]);
                end
            end
            checks++;
            if (wrap_cnt !== WCNT_W'(exp_wrap) || overflow !== exp_ovf) begin
                errors++;
                $display("FAIL rand_status[%0d]: got wrap=%0d ovf=%0b expected wrap=%0d ovf=%0b",
                         n, wrap_cnt, overflow, exp_wrap, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reversal();
        test_wrap_dn();
        test_jump();
        test_overflow();
        test_wrap_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
